// File: rtl/ps2_hex_entry.sv
// PS/2 keyboard hex-digit entry: receives scancodes and assembles a 64-bit data block and a 128-bit key.
// Optional macro PS2_PARITY_CHECK_EN enables odd-parity rejection of received frames.
module ps2_hex_entry #(
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ps2_clk,
    input  logic         ps2_data,
    input  logic         sel_value,
    input  logic         sel_key,
    input  logic         start,
    output logic [63:0]  din,
    output logic [127:0] key,
    output logic         di_vld,
    output logic [4:0]   val_cnt,
    output logic [5:0]   key_cnt,
    output logic         frame_err
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;

    logic          ps2c_s1_q, ps2c_s2_q, ps2c_p_q, ps2d_s1_q, ps2d_s2_q;
    state_t        state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d, stop_q, stop_d;
    logic [TW-1:0] to_q, to_d;
    logic          ferr_q, ferr_d;
    logic          brk_q, brk_d;
    logic          start_p_q;
    logic [63:0]   din_q, din_d;
    logic [127:0]  key_q, key_d;
    logic [4:0]    val_cnt_q, val_cnt_d;
    logic [5:0]    key_cnt_q, key_cnt_d;
    logic          di_vld_q, di_vld_d;
    logic          fall, rx_vld, par_ok;
    logic [4:0]    hex;

    assign fall = ps2c_p_q & ~ps2c_s2_q;

    function automatic logic [4:0] hex_of(input logic [7:0] sc);
        case (sc)
            8'h45: return 5'h10;
            8'h16: return 5'h11;
            8'h1E: return 5'h12;
            8'h26: return 5'h13;
            8'h25: return 5'h14;
            8'h2E: return 5'h15;
            8'h36: return 5'h16;
            8'h3D: return 5'h17;
            8'h3E: return 5'h18;
            8'h46: return 5'h19;
            8'h1C: return 5'h1A;
            8'h32: return 5'h1B;
            8'h21: return 5'h1C;
            8'h23: return 5'h1D;
            8'h24: return 5'h1E;
            8'h2B: return 5'h1F;
            default: return 5'h00;
        endcase
    endfunction

    always_comb begin
`ifdef PS2_PARITY_CHECK_EN
        par_ok = ^{shift_q, par_q};
`else
        par_ok = par_q | ~par_q;
`endif
    end

    // Receiver: bits are taken on falling edges of the synchronized PS/2 clock
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_d     = par_q;
        stop_d    = stop_q;
        to_d      = to_q;
        ferr_d    = 1'b0;
        rx_vld    = 1'b0;
        case (state_q)
            IDLE: begin
                to_d      = '0;
                bit_cnt_d = '0;
                if (fall && !ps2d_s2_q) state_d = RECV;
            end
            RECV: begin
                if (fall) begin
                    to_d      = '0;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q < 4'd8) begin
                        shift_d = {ps2d_s2_q, shift_q[7:1]};
                    end else if (bit_cnt_q == 4'd8) begin
                        par_d = ps2d_s2_q;
                    end else begin
                        stop_d  = ps2d_s2_q;
                        state_d = CHECK;
                    end
                end else if (to_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d = IDLE;
                    ferr_d  = 1'b1;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            CHECK: begin
                state_d = IDLE;
                if (stop_q && par_ok) rx_vld = 1'b1;
                else                  ferr_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Decoder: acts on the byte during the CHECK cycle
    always_comb begin
        din_d     = din_q;
        key_d     = key_q;
        val_cnt_d = val_cnt_q;
        key_cnt_d = key_cnt_q;
        brk_d     = brk_q;
        di_vld_d  = start & ~start_p_q;
        hex       = hex_of(shift_q);
        if (rx_vld) begin
            if (shift_q == 8'hE0) begin
                brk_d = brk_q;
            end else if (brk_q) begin
                brk_d = 1'b0;
            end else if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (hex[4]) begin
                if (sel_value) begin
                    din_d = {din_q[59:0], hex[3:0]};
                    if (val_cnt_q != 5'd16) val_cnt_d = val_cnt_q + 5'd1;
                end else if (sel_key) begin
                    key_d = {key_q[123:0], hex[3:0]};
                    if (key_cnt_q != 6'd32) key_cnt_d = key_cnt_q + 6'd1;
                end
            end else if (shift_q == 8'h66) begin
                if (sel_value) begin
                    din_d = {4'h0, din_q[63:4]};
                    if (val_cnt_q != 5'd0) val_cnt_d = val_cnt_q - 5'd1;
                end else if (sel_key) begin
                    key_d = {4'h0, key_q[127:4]};
                    if (key_cnt_q != 6'd0) key_cnt_d = key_cnt_q - 6'd1;
                end
            end else if (shift_q == 8'h5A) begin
                di_vld_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ps2c_s1_q <= 1'b0;
            ps2c_s2_q <= 1'b0;
            ps2c_p_q  <= 1'b0;
            ps2d_s1_q <= 1'b0;
            ps2d_s2_q <= 1'b0;
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            par_q     <= 1'b0;
            stop_q    <= 1'b0;
            to_q      <= '0;
            ferr_q    <= 1'b0;
            brk_q     <= 1'b0;
            start_p_q <= 1'b0;
            din_q     <= '0;
            key_q     <= '0;
            val_cnt_q <= '0;
            key_cnt_q <= '0;
            di_vld_q  <= 1'b0;
        end else begin
            ps2c_s1_q <= ps2_clk;
            ps2c_s2_q <= ps2c_s1_q;
            ps2c_p_q  <= ps2c_s2_q;
            ps2d_s1_q <= ps2_data;
            ps2d_s2_q <= ps2d_s1_q;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            par_q     <= par_d;
            stop_q    <= stop_d;
            to_q      <= to_d;
            ferr_q    <= ferr_d;
            brk_q     <= brk_d;
            start_p_q <= start;
            din_q     <= din_d;
            key_q     <= key_d;
            val_cnt_q <= val_cnt_d;
            key_cnt_q <= key_cnt_d;
            di_vld_q  <= di_vld_d;
        end
    end

    assign din       = din_q;
    assign key       = key_q;
    assign val_cnt   = val_cnt_q;
    assign key_cnt   = key_cnt_q;
    assign di_vld    = di_vld_q;
    assign frame_err = ferr_q;
endmodule

// File: tb/tb_ps2_hex_entry.sv
// Directed bench for ps2_hex_entry: bit-bangs PS/2 frames and checks the assembled registers and strobes.
module tb_ps2_hex_entry;
    localparam int TO = 200;
    localparam int H  = 10;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         ps2_clk = 1'b1;
    logic         ps2_data = 1'b1;
    logic         sel_value = 1'b0;
    logic         sel_key = 1'b0;
    logic         start = 1'b0;
    logic [63:0]  din;
    logic [127:0] key;
    logic         di_vld;
    logic [4:0]   val_cnt;
    logic [5:0]   key_cnt;
    logic         frame_err;

    int checks = 0;
    int passed = 0;
    int vld_cnt = 0;
    int ferr_cnt = 0;
    logic [63:0]  cap_din;
    logic [127:0] cap_key;
    logic [7:0]   sc_tab [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                  8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};

    ps2_hex_entry #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .sel_value(sel_value), .sel_key(sel_key), .start(start),
        .din(din), .key(key), .di_vld(di_vld), .val_cnt(val_cnt),
        .key_cnt(key_cnt), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (di_vld) begin
            vld_cnt++;
            cap_din = din;
            cap_key = key;
        end
        if (frame_err) ferr_cnt++;
    end

    task automatic send_bits(input logic [7:0] b, input bit bad_par, input int n);
        logic [10:0] fr;
        fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < n; i++) begin
            ps2_data = fr[i];
            repeat (H) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (H) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (H) @(negedge clk);
    endtask

    task automatic press(input logic [7:0] b);
        send_bits(b, 1'b0, 11);
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic test_reset();
        checks++; if (din !== 64'h0) $display("FAIL reset_din: got %h expected 0", din); else passed++;
        checks++; if (key !== 128'h0) $display("FAIL reset_key: got %h expected 0", key); else passed++;
        checks++; if (val_cnt !== 5'd0 || key_cnt !== 6'd0)
            $display("FAIL reset_cnt: got %0d/%0d expected 0/0", val_cnt, key_cnt); else passed++;
        checks++; if (di_vld !== 1'b0 || frame_err !== 1'b0)
            $display("FAIL reset_strobes: got %b%b expected 00", di_vld, frame_err); else passed++;
    endtask

    task automatic test_value_break();
        int f0;
        do_reset();
        f0 = ferr_cnt;
        sel_value = 1'b1;
        press(8'h1E); press(8'hF0); press(8'h1E); press(8'h1C);
        checks++; if (din !== 64'h2A) $display("FAIL break_din: got %h expected 2a", din); else passed++;
        checks++; if (val_cnt !== 5'd2) $display("FAIL break_cnt: got %0d expected 2", val_cnt); else passed++;
        checks++; if (ferr_cnt != f0) $display("FAIL break_ferr: got %0d expected 0", ferr_cnt - f0); else passed++;
    endtask

    task automatic test_key_sat();
        do_reset();
        sel_value = 1'b0; sel_key = 1'b1;
        for (int i = 0; i < 32; i++) press(8'h16);
        press(8'h45);
        checks++; if (key !== 128'h1111_1111_1111_1111_1111_1111_1111_1110)
            $display("FAIL key_sat: got %h expected 1111...1110", key); else passed++;
        checks++; if (key_cnt !== 6'd32) $display("FAIL key_cnt_sat: got %0d expected 32", key_cnt); else passed++;
    endtask

    task automatic test_backspace();
        press(8'h66);
        checks++; if (key !== 128'h0111_1111_1111_1111_1111_1111_1111_1111)
            $display("FAIL bksp_key: got %h expected 0111...1111", key); else passed++;
        checks++; if (key_cnt !== 6'd31) $display("FAIL bksp_key_cnt: got %0d expected 31", key_cnt); else passed++;
        sel_value = 1'b1;
        press(8'h66);
        checks++; if (val_cnt !== 5'd0 || din !== 64'h0)
            $display("FAIL bksp_floor: got %0d/%h expected 0/0", val_cnt, din); else passed++;
        sel_value = 1'b0; sel_key = 1'b0;
        press(8'h16);
        checks++; if (din !== 64'h0 || key_cnt !== 6'd31 || key !== 128'h0111_1111_1111_1111_1111_1111_1111_1111)
            $display("FAIL nosel_digit: got din %h key_cnt %0d expected 0/31", din, key_cnt); else passed++;
    endtask

    task automatic test_enter();
        logic [63:0] v;
        int v0;
        v = 64'hEEDB_A521_6D8F_4B15;
        do_reset();
        sel_key = 1'b1; sel_value = 1'b0;
        press(8'h16);
        sel_value = 1'b1;
        for (int i = 15; i >= 0; i--) press(sc_tab[v[i*4 +: 4]]);
        v0 = vld_cnt;
        press(8'h5A);
        checks++; if (vld_cnt - v0 != 1) $display("FAIL enter_pulses: got %0d expected 1", vld_cnt - v0); else passed++;
        chk64("enter_din", cap_din, v);
        checks++; if (cap_key !== 128'h1) $display("FAIL enter_key: got %h expected 1", cap_key); else passed++;
        chk64("enter_din_kept", din, v);
        checks++; if (val_cnt !== 5'd16 || key_cnt !== 6'd1)
            $display("FAIL enter_cnt: got %0d/%0d expected 16/1", val_cnt, key_cnt); else passed++;
    endtask

    task automatic test_start();
        int v0;
        v0 = vld_cnt;
        @(negedge clk) start = 1'b1;
        repeat (20) @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        checks++; if (vld_cnt - v0 != 1) $display("FAIL start_pulses: got %0d expected 1", vld_cnt - v0); else passed++;
        chk64("start_din", cap_din, 64'hEEDB_A521_6D8F_4B15);
    endtask

    task automatic test_parity();
        int f0;
        do_reset();
        sel_value = 1'b1; sel_key = 1'b0;
        f0 = ferr_cnt;
        send_bits(8'h16, 1'b1, 11);
`ifdef PS2_PARITY_CHECK_EN
        checks++; if (ferr_cnt - f0 != 1) $display("FAIL parity_ferr: got %0d expected 1", ferr_cnt - f0); else passed++;
        chk64("parity_din", din, 64'h0);
`else
        checks++; if (ferr_cnt != f0) $display("FAIL parity_ferr: got %0d expected 0", ferr_cnt - f0); else passed++;
        chk64("parity_din", din, 64'h1);
`endif
    endtask

    task automatic test_timeout();
        int f0;
        do_reset();
        f0 = ferr_cnt;
        send_bits(8'h16, 1'b0, 4);
        repeat (TO + 10) @(negedge clk);
        checks++; if (ferr_cnt - f0 != 1) $display("FAIL timeout_ferr: got %0d expected 1", ferr_cnt - f0); else passed++;
        press(8'h16);
        chk64("timeout_din", din, 64'h1);
        checks++; if (ferr_cnt - f0 != 1) $display("FAIL timeout_ferr_after: got %0d expected 1", ferr_cnt - f0); else passed++;
    endtask

    task automatic test_reset_mid();
        int v0, f0;
        do_reset();
        sel_value = 1'b1;
        send_bits(8'h1E, 1'b0, 4);
        v0 = vld_cnt; f0 = ferr_cnt;
        do_reset();
        press(8'h66);
        checks++; if (val_cnt !== 5'd0 || key_cnt !== 6'd0)
            $display("FAIL rstmid_cnt: got %0d/%0d expected 0/0", val_cnt, key_cnt); else passed++;
        checks++; if (vld_cnt != v0 || ferr_cnt != f0)
            $display("FAIL rstmid_strobes: got vld %0d ferr %0d expected 0/0", vld_cnt - v0, ferr_cnt - f0); else passed++;
        press(8'h26);
        chk64("rstmid_next", din, 64'h3);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_value_break();
        test_key_sat();
        test_backspace();
        test_enter();
        test_start();
        test_parity();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/ps2_hex_entry.md
PS2_HEX_ENTRY -- requirements
Module: ps2_hex_entry

Interface
REQ-001 Parameter TIMEOUT_CYC, default 100000: clk cycles without a PS/2 falling edge, mid-frame, before the frame is abandoned.
REQ-002 clk  input  1  system clock; every flop in the block SHALL be clocked on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ps2_clk  input  1  raw keyboard clock; asynchronous to clk.
REQ-005 ps2_data  input  1  raw keyboard data; asynchronous to clk.
REQ-006 sel_value  input  1  level; routes hex digits to din.
REQ-007 sel_key  input  1  level; routes hex digits to key.
REQ-008 start  input  1  level; its rising edge requests a block.
REQ-009 din  output  64  assembled plaintext or ciphertext block, fed to the encrypt or decrypt stage.
REQ-010 key  output  128  assembled key.
REQ-011 di_vld  output  1  one-cycle strobe; din and key are valid in that cycle.
REQ-012 val_cnt  output  5  number of digits entered into din, saturating at 16.
REQ-013 key_cnt  output  6  number of digits entered into key, saturating at 32.
REQ-014 frame_err  output  1  one-cycle strobe on a rejected frame.

Function
REQ-015 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer; a bit is sampled on a detected falling edge of the synchronized ps2_clk.
REQ-016 Receiver FSM states:
- IDLE -> RECV when a falling edge samples data=0 (start bit).
- RECV collects 8 data bits (LSB first), then a parity bit, then a stop bit.
- After the stop bit -> CHECK, which lasts one cycle, then -> IDLE.
REQ-017 In CHECK, the frame is accepted if stop=1 and the parity check (REQ-032) passes; otherwise frame_err pulses and the byte is discarded.
REQ-018 In RECV, TIMEOUT_CYC cycles with no falling edge SHALL return the FSM to IDLE, discard the partial frame and pulse frame_err.
REQ-019 Decoder handling of accepted bytes:
- 0xE0 is ignored.
- 0xF0 sets a break flag; the next accepted byte is consumed and clears the flag, with no action.
REQ-020 Hex digit scancodes:
- 0-9 = 45,16,1E,26,25,2E,36,3D,3E,46.
- A-F = 1C,32,21,23,24,2B.
REQ-021 Digit to din (sel_value=1): din <= {din[59:0], nibble}; val_cnt increments, saturating at 16.
REQ-022 Digit to key (sel_value=0, sel_key=1): key <= {key[123:0], nibble}; key_cnt increments, saturating at 32.
REQ-023 Digit with both selects 0: ignored.
REQ-024 Backspace (0x66) to the selected target shifts it right by 4 bits, zero-filling the top; the count decrements and SHALL NOT go below 0.
REQ-025 Enter (0x5A), or a rising edge of start, SHALL assert di_vld for exactly one cycle, in the cycle after the event is detected.
REQ-026 din, key and both counts are unchanged by di_vld.
REQ-027 If a digit and a start edge resolve in the same cycle, the digit is applied first and di_vld fires in the following cycle, showing the updated din or key.
REQ-028 All other scancodes are ignored.
REQ-029 Latency from the stop-bit falling edge to a register update SHALL be at most 5 clk cycles.

Reset
REQ-030 reset SHALL clear din, key, val_cnt, key_cnt, di_vld, frame_err, the break flag and the synchronizers, and force the FSM to IDLE.
REQ-031 A reset asserted mid-frame discards the partial frame; the next frame decodes correctly.

Configuration
REQ-032 Macro PS2_PARITY_CHECK_EN:
- Defined: odd parity over the 8 data bits plus the parity bit is required; a mismatch rejects the frame per REQ-017.
- Undefined: the parity bit is sampled but ignored, and only a bad stop bit or a timeout raises frame_err.

Verification
REQ-033 Send frames 1E,F0,1E then 1C with sel_value=1 -> din=64'h2A, val_cnt=2.
REQ-034 Send 32 frames of 16 ("1") with sel_key=1, then 45 ("0") -> key=128'h1111...1110, key_cnt=32.
REQ-035 din=64'hEEDBA5216D8F4B15, key=128'h1; send 5A -> di_vld high for exactly 1 cycle carrying those values.
REQ-036 Frame with a flipped parity bit:
- Macro defined -> frame_err pulses and din is unchanged.
- Macro undefined -> the digit is accepted.
REQ-037 Stop clocking after 4 bits, wait TIMEOUT_CYC+10 cycles, then send a valid 16 -> frame_err pulses once, then din=64'h1.
REQ-038 Assert reset for 1 cycle in the middle of a frame, then send a valid 66 with val_cnt=0 -> counts stay 0, no di_vld, no frame_err.
